// File: rtl/instr_fetch_unit.sv
// Sequential instruction-fetch front end: holds the PC and fetches over a req/ack handshake.
// It presents each word for one issue window, then picks the next PC from Branch/Jump/Zero.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic        stall,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic [31:0] r_retired;

    logic [31:0]        w_pc_plus4;
    logic signed [31:0] w_br_off;
    logic [31:0]        w_br_target;
    logic [31:0]        w_jmp_target;
    logic [31:0]        w_next_pc;

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [31:0] ins);
        return {pc4[31:28], ins[25:0], 2'b00};
    endfunction

    assign w_pc_plus4   = r_pc + 32'd4;
    // Sign-extend the 16-bit offset first, then shift: offsets span +/-128 KiB.
    assign w_br_off     = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_target  = w_pc_plus4 + unsigned'(w_br_off);
    assign w_jmp_target = jump_target(w_pc_plus4, r_instr);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Jump) begin
            w_next_pc = w_jmp_target;
        end else if (Branch && Zero) begin
            w_next_pc = w_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_retired     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_state       <= S_ISSUE;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // A stalled window freezes everything; acks here are ignored.
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_retired     <= r_retired + 32'd1;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a PC/retire reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic        stall;
    logic [31:0] retired;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .stall(stall),
        .retired(retired)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference next-PC rule written with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic br, input logic jp, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
        if (br && z) begin
            off = int'($signed(ins[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        m_instr   = 32'd0;
        m_retired = 32'd0;
    endtask

    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : $urandom;
            Branch     = 1'($urandom);
            Jump       = 1'($urandom);
            Zero       = 1'($urandom);
            stall      = 1'($urandom);
            step();
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        m_instr  = word;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_req", {31'd0, imem_req}, 32'd0);
        chk("issue_instr", instr, m_instr);
        chk("issue_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
        chk("issue_pc", pc, m_pc);
        chk("issue_pc4", pc_plus4, m_pc + 32'd4);
        chk("issue_retired", retired, m_retired);
    endtask

    task automatic issue(input int stalls, input logic br, input logic jp, input logic z);
        for (int i = 0; i < stalls; i++) begin
            stall      = 1'b1;
            Branch     = 1'($urandom);
            Jump       = 1'($urandom);
            Zero       = 1'($urandom);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            chk("stall_instr", instr, m_instr);
            chk("stall_pc", pc, m_pc);
            chk("stall_retired", retired, m_retired);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        Branch   = br;
        Jump     = jp;
        Zero     = z;
        step();
        m_pc      = model_next(m_pc, m_instr, br, jp, z);
        m_retired = m_retired + 32'd1;
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, m_pc);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);
        chk("next_retired", retired, m_retired);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Zero       = 1'b0;
        stall      = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", {26'd0, opcode}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        reset = 1'b0;
        step();

        // Sequential R-type stream, zero-wait memory.
        for (int i = 0; i < 4; i++) begin
            fetch(0, $urandom & 32'h03FF_FFFF);
            issue(0, 1'b0, 1'b0, 1'b0);
        end
        chk("seq_retired4", retired, 32'd4);
        chk("seq_addr16", imem_addr, 32'd16);

        // Jump to 0x40, then BEQ taken / negative offset / not taken.
        fetch(0, 32'h0800_0010);  issue(0, 1'b0, 1'b1, 1'b0);
        chk("jmp_to_40", imem_addr, 32'h40);
        fetch(0, 32'h1000_0003);  issue(0, 1'b1, 1'b0, 1'b1);
        chk("beq_taken", imem_addr, 32'h50);
        fetch(0, 32'h0800_0010);  issue(0, 1'b0, 1'b1, 1'b0);
        fetch(0, 32'h1000_FFFF);  issue(0, 1'b1, 1'b0, 1'b1);
        chk("beq_neg", imem_addr, 32'h40);
        fetch(0, 32'h1000_0003);  issue(0, 1'b1, 1'b0, 1'b0);
        chk("beq_not_taken", imem_addr, 32'h44);

        // Reach 0x1000_0000 via a max jump plus one sequential step.
        fetch(0, 32'h0BFF_FFFF);  issue(0, 1'b0, 1'b1, 1'b0);
        chk("jmp_max", imem_addr, 32'h0FFF_FFFC);
        fetch(0, 32'h0000_0020);  issue(0, 1'b0, 1'b0, 1'b0);
        chk("seq_region", imem_addr, 32'h1000_0000);
        fetch(0, 32'h0800_0010);  issue(0, 1'b0, 1'b1, 1'b0);
        chk("jmp_region", imem_addr, 32'h1000_0040);
        fetch(0, 32'h0400_0000);  issue(0, 1'b0, 1'b1, 1'b0);
        fetch(0, 32'h0800_0010);  issue(0, 1'b1, 1'b1, 1'b1);
        chk("jmp_priority", imem_addr, 32'h1000_0040);

        // Wait states, stalls with spurious acks.
        fetch(3, 32'h2108_0001);
        issue(5, 1'b0, 1'b0, 1'b0);

        // Reset during a fetch wait; an ack one cycle later must be ignored.
        imem_ack = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_retired", retired, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        fetch(1, 32'h0123_4567);
        issue(0, 1'b0, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            fetch(int'($urandom_range(0, 3)), $urandom);
            issue(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
